// File: rtl/block_4x32_feeder.sv
// Skewed A/B operand feeder for the 4x32 block multiplier (8 x 4x4 arrays).
// Optional drain watchdog: define FEEDER_DRAIN_TIMEOUT_EN.
module block_4x32_feeder #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [6:0]             wr_addr,
    input  logic [BIT_WIDTH-1:0]   wr_data,
    input  logic                   start,
    input  logic                   done_in,
    output logic [4*BIT_WIDTH-1:0] west_in0,
    output logic [4*BIT_WIDTH-1:0] west_in1,
    output logic [4*BIT_WIDTH-1:0] west_in2,
    output logic [4*BIT_WIDTH-1:0] west_in3,
    output logic [4*BIT_WIDTH-1:0] west_in4,
    output logic [4*BIT_WIDTH-1:0] west_in5,
    output logic [4*BIT_WIDTH-1:0] west_in6,
    output logic [4*BIT_WIDTH-1:0] west_in7,
    output logic [4*BIT_WIDTH-1:0] north_in0,
    output logic [4*BIT_WIDTH-1:0] north_in1,
    output logic [4*BIT_WIDTH-1:0] north_in2,
    output logic [4*BIT_WIDTH-1:0] north_in3,
    output logic [4*BIT_WIDTH-1:0] north_in4,
    output logic [4*BIT_WIDTH-1:0] north_in5,
    output logic [4*BIT_WIDTH-1:0] north_in6,
    output logic [4*BIT_WIDTH-1:0] north_in7,
    output logic                   busy,
    output logic                   tile_done,
    output logic                   timeout_err
);
    localparam int LW = 4 * BIT_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t               state_q;
    logic [2:0]           t_q;
    logic [2:0]           step;
    logic                 wr_ok;
    logic                 busy_q;
    logic                 done_q;
    logic [BIT_WIDTH-1:0] a_q [128];
    logic [BIT_WIDTH-1:0] b_q [128];
    logic [LW-1:0]        west_q [8];
    logic [LW-1:0]        north_q [8];
    logic [LW-1:0]        west_d [8];
    logic [LW-1:0]        north_d [8];
`ifdef FEEDER_DRAIN_TIMEOUT_EN
    logic [4:0]           cnt_q;
    logic                 tmo_q;
`endif

    assign wr_ok = wr_en && (state_q == IDLE);
    // Step whose words are loaded at the coming edge.
    assign step  = (state_q == IDLE) ? 3'd0 : t_q + 3'd1;

    // Same-cycle writes are forwarded so a start can use them.
    always_comb begin
        int         d;
        logic [6:0] ia;
        logic [6:0] ib;
        d  = 0;
        ia = '0;
        ib = '0;
        for (int i = 0; i < 8; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            for (int l = 0; l < 4; l++) begin
                d  = int'(step) - l;
                ia = {2'(l), 5'(4 * i + d)};
                ib = {5'(4 * i + d), 2'(l)};
                if (d >= 0 && d <= 3) begin
                    west_d[i][(3-l)*BIT_WIDTH +: BIT_WIDTH] =
                        (wr_ok && !wr_sel && wr_addr == ia) ?
                        wr_data : a_q[ia];
                    north_d[i][(3-l)*BIT_WIDTH +: BIT_WIDTH] =
                        (wr_ok && wr_sel && wr_addr == ib) ?
                        wr_data : b_q[ib];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
`ifdef FEEDER_DRAIN_TIMEOUT_EN
            cnt_q <= '0;
            tmo_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (wr_ok) begin
                if (wr_sel) b_q[wr_addr] <= wr_data;
                else        a_q[wr_addr] <= wr_data;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        west_q  <= west_d;
                        north_q <= north_d;
                    end
                end
                STREAM: begin
                    if (t_q == 3'd6) begin
                        state_q <= DRAIN;
                        for (int i = 0; i < 8; i++) begin
                            west_q[i]  <= '0;
                            north_q[i] <= '0;
                        end
`ifdef FEEDER_DRAIN_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end else begin
                        t_q     <= t_q + 3'd1;
                        west_q  <= west_d;
                        north_q <= north_d;
                    end
                end
                DRAIN: begin
                    if (done_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
`ifdef FEEDER_DRAIN_TIMEOUT_EN
                    else if (cnt_q == 5'd31) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign west_in0  = west_q[0];
    assign west_in1  = west_q[1];
    assign west_in2  = west_q[2];
    assign west_in3  = west_q[3];
    assign west_in4  = west_q[4];
    assign west_in5  = west_q[5];
    assign west_in6  = west_q[6];
    assign west_in7  = west_q[7];
    assign north_in0 = north_q[0];
    assign north_in1 = north_q[1];
    assign north_in2 = north_q[2];
    assign north_in3 = north_q[3];
    assign north_in4 = north_q[4];
    assign north_in5 = north_q[5];
    assign north_in6 = north_q[6];
    assign north_in7 = north_q[7];
    assign busy      = busy_q;
    assign tile_done = done_q;
`ifdef FEEDER_DRAIN_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/block_4x32_feeder.md
# block_4x32_feeder

Tile feeder that drives the skewed operand streams consumed by the 4x32 block multiplier (eight 4x4 output-stationary systolic arrays plus adder tree). It stores one A tile (4 rows x 32 k) and one B tile (32 k x 4 columns), then on `start` emits the diagonally skewed west (A) and north (B) words for all eight arrays in parallel. It waits for the multiplier's `done` and reports tile completion. It is the transmitter end of the `north_inN`/`west_inN` interface.

## Interface
- `BIT_WIDTH`, 16, operand width (two's complement, fixed-point; not interpreted here)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  tile write strobe
- `wr_sel`  in  1  0 = A tile, 1 = B tile
- `wr_addr`  in  7  A: {r[1:0], k[4:0]}; B: {k[4:0], c[1:0]}
- `wr_data`  in  BIT_WIDTH  operand value
- `start`  in  1  begin streaming the stored tiles
- `done_in`  in  1  completion pulse from the multiplier
- `west_in0`..`west_in7`  out  4*BIT_WIDTH each  A lanes for array i; lane 0 (row 0) in MSBs
- `north_in0`..`north_in7`  out  4*BIT_WIDTH each  B lanes for array i; lane 0 (column 0) in MSBs
- `busy`  out  1  high in STREAM or DRAIN
- `tile_done`  out  1  one-cycle pulse on return to IDLE
- `timeout_err`  out  1  sticky drain-timeout flag (see Configuration)

## Operation
- Storage: 128 A words plus 128 B words, all reset to 0. Writes are accepted only in IDLE. `wr_en` in STREAM or DRAIN is ignored.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: all stream outputs are 0. On `start`, go to STREAM with t=0. A write in the same cycle as `start` commits and is used by the stream.
- STREAM: t counts 0..6, one step per cycle. Array i covers k = 4i..4i+3.
  - West lane r = A[r][4i + t - r] when 0 <= t-r <= 3, else 0.
  - North lane c = B[4i + t - c][c] when 0 <= t-c <= 3, else 0.
  - After t=6, go to DRAIN.
- DRAIN: outputs are 0. On `done_in`, go to IDLE and pulse `tile_done`.
- `done_in` outside DRAIN is ignored. `start` while `busy` is ignored.
- No arithmetic is performed. Words pass through bit-exact.
- Reset at any time, including mid-stream: state IDLE, all outputs 0, storage 0, `timeout_err` 0.

## Timing
- Every output is registered. Reset value of every output is 0.
- If `start` is sampled at edge n, the t=0 words are on the outputs from edge n onward, and `busy`=1 from edge n.
- The t=6 words are visible after edge n+6. Zeros follow from edge n+7 (DRAIN).
- If `done_in` is sampled at edge m in DRAIN, then after edge m `busy`=0 and `tile_done`=1 for exactly one cycle.
- Minimum start-to-start spacing is 9 cycles: 7 STREAM + at least 1 DRAIN + 1 IDLE.
- A write at edge j is readable by a stream starting at edge j or later.

## Configuration
- `FEEDER_DRAIN_TIMEOUT_EN` defined:
  - A 5-bit counter runs in DRAIN.
  - If 32 cycles pass in DRAIN without `done_in`, the FSM returns to IDLE, pulses `tile_done`, and sets `timeout_err`.
  - `timeout_err` clears only on `rst`.
- Not defined: DRAIN waits indefinitely, and `timeout_err` is constant 0.

## Test plan
- Reset mid-STREAM at t=3 -> all outputs 0 asynchronously, `busy`=0. After release, a new `start` streams all-zero data.
- Load A[r][k]=k+1, B[k][c]=c+1, pulse `start` -> at t=0, `west_in0`={1,0,0,0} and `north_in0`={1,0,0,0}. At t=3, `west_in2` lanes={12,11,10,9} and `north_in2` lanes={1,2,3,4}. At t=6, only lane 3 is nonzero (A[3][4i+3], B[4i+3][3]).
- `wr_en` with `wr_sel`=0, addr {2,5}, data 0x7FFF during STREAM -> ignored. The next stream shows the prior value at that position.
- `start` and a write to A[0][0]=0x0100 in the same cycle -> `west_in0` lane 0 = 0x0100 at t=0.
- `done_in` pulsed during STREAM, then again 3 cycles into DRAIN -> first pulse ignored. The second pulse gives `tile_done` high for one cycle and `busy` low.
- With `FEEDER_DRAIN_TIMEOUT_EN`, no `done_in` -> exactly 32 DRAIN cycles, then `tile_done` pulses and `timeout_err`=1 until `rst`. Without the macro -> `busy` stays 1 for 100+ cycles.
